// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: arbitrates the single regfile write port between pipeline
// writeback and a buffered multi-cycle unit, with a pending-write scoreboard.
// Optional: define MC_CUT_THROUGH_EN to let an mc result bypass an empty FIFO.
module regfile_wr_arb #(
    parameter int MC_DEPTH = 2,
    parameter int REG_NUM  = 32
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        mc_valid,
    input  logic [4:0]  mc_wa,
    input  logic [31:0] mc_wd,
    output logic        mc_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wa,
    input  logic [4:0]  ra1,
    input  logic        re1,
    input  logic [4:0]  ra2,
    input  logic        re2,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam int PW = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]         fifo_wa_q [MC_DEPTH];
    logic [31:0]        fifo_wd_q [MC_DEPTH];
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [REG_NUM-1:0] pend_q, pend_d;

    logic        empty, full;
    logic        push, pop, ct, drain;
    logic [4:0]  head_wa, drain_wa;
    logic [31:0] head_wd, drain_wd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(MC_DEPTH));
    assign head_wa = fifo_wa_q[rd_ptr_q];
    assign head_wd = fifo_wd_q[rd_ptr_q];

    // A register whose result is being written this cycle is not a hazard
    function automatic logic hit(input logic [4:0] r);
        hit = pend_q[r] && !(drain && (drain_wa == r));
    endfunction

    // Drain selection, FIFO handshake and write-port mux
    always_comb begin
        mc_ready = cpu_rst_n && !full;
        pop      = cpu_rst_n && !wb_we && !empty;
        ct       = 1'b0;
        drain_wa = head_wa;
        drain_wd = head_wd;
`ifdef MC_CUT_THROUGH_EN
        ct = cpu_rst_n && empty && !wb_we && mc_valid;
        if (ct) begin
            drain_wa = mc_wa;
            drain_wd = mc_wd;
        end
`endif
        drain = pop || ct;
        push  = mc_valid && mc_ready && !ct;
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (cpu_rst_n) begin
            if (wb_we) begin
                rf_we = 1'b1;
                rf_wa = wb_wa;
                rf_wd = wb_wd;
            end else if (drain) begin
                rf_we = (drain_wa != 5'd0);
                rf_wa = drain_wa;
                rf_wd = drain_wd;
            end
        end
    end

    // Hazard detection and scoreboard next state
    always_comb begin
        stall_req = cpu_rst_n && (
            (re1 && (ra1 != 5'd0) && hit(ra1)) ||
            (re2 && (ra2 != 5'd0) && hit(ra2)) ||
            (issue_valid && (issue_wa != 5'd0) && pend_q[issue_wa]));
        pend_d = pend_q;
        if (drain && (drain_wa != 5'd0))
            pend_d[drain_wa] = 1'b0;
        if (issue_valid && !stall_req && (issue_wa != 5'd0))
            pend_d[issue_wa] = 1'b1;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < MC_DEPTH; i++) begin
                fifo_wa_q[i] <= '0;
                fifo_wd_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_wa_q[wr_ptr_q] <= mc_wa;
                fifo_wd_q[wr_ptr_q] <= mc_wd;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Pending-write scoreboard register
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed self-checking bench.
// Expected values are hand-computed.
`define CHK(tag, obs, exp) \
  checks++; \
  assert ((obs) === (exp)) else begin \
    failures++; \
    $error("FAIL %s obs=%0h exp=%0h", \
      tag, obs, exp); \
  end

module tb_regfile_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, mc_valid;
  logic        issue_valid, re1, re2;
  logic [4:0]  wb_wa, mc_wa, issue_wa;
  logic [4:0]  ra1, ra2;
  logic [31:0] wb_wd, mc_wd;
  logic        mc_ready, stall_req, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  int          checks = 0;
  int          failures = 0;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  regfile_wr_arb #(
    .MC_DEPTH(2),
    .REG_NUM(32)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n(rst_n),
    .wb_we(wb_we),
    .wb_wa(wb_wa),
    .wb_wd(wb_wd),
    .mc_valid(mc_valid),
    .mc_wa(mc_wa),
    .mc_wd(mc_wd),
    .mc_ready(mc_ready),
    .issue_valid(issue_valid),
    .issue_wa(issue_wa),
    .ra1(ra1),
    .re1(re1),
    .ra2(ra2),
    .re2(re2),
    .stall_req(stall_req),
    .rf_we(rf_we),
    .rf_wa(rf_wa),
    .rf_wd(rf_wd)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_rst(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL rst %s obs=%0h exp=%0h",
        tag, obs, exp);
    end
  endtask

  initial begin
    #5000;
    if (!done) begin
      failures++;
      $error("FAIL timeout: wait expired");
      $display("TB_RESULT checks=%0d failures=%0d",
        checks, failures);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    wb_we = 1'b1; wb_wa = 5'd5;
    wb_wd = 32'h11;
    mc_valid = 1'b0; mc_wa = '0; mc_wd = '0;
    issue_valid = 1'b0; issue_wa = '0;
    re1 = 1'b0; ra1 = '0;
    re2 = 1'b0; ra2 = '0;
    #3;
    chk_rst("rf_we", 32'(rf_we), 32'd0);
    chk_rst("rf_wa", 32'(rf_wa), 32'd0);
    chk_rst("rf_wd", rf_wd, 32'd0);
    chk_rst("mc_ready", 32'(mc_ready), 32'd0);
    chk_rst("stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc();
    #1;
    `CHK("t1_rf_we", rf_we, 1'b1)
    `CHK("t1_rf_wa", rf_wa, 5'd5)
    `CHK("t1_rf_wd", rf_wd, 32'h11)
    `CHK("t1_mc_ready", mc_ready, 1'b1)
    `CHK("t1_stall", stall_req, 1'b0)

    cyc();
    wb_we = 1'b0; issue_valid = 1'b1;
    issue_wa = 5'd8;
    #1;
    `CHK("t2_issue_nostall", stall_req, 1'b0)
    cyc();
    issue_valid = 1'b0; re1 = 1'b1;
    ra1 = 5'd8;
    #1;
    `CHK("t2_raw_stall", stall_req, 1'b1)
    cyc();
    mc_valid = 1'b1; mc_wa = 5'd8;
    mc_wd = 32'hDEAD;
    #1;
`ifdef MC_CUT_THROUGH_EN
    `CHK("t2_ct_rf_we", rf_we, 1'b1)
    `CHK("t2_ct_rf_wd", rf_wd, 32'hDEAD)
    `CHK("t2_ct_stall", stall_req, 1'b0)
`else
    `CHK("t2_accept_rf_we", rf_we, 1'b0)
    `CHK("t2_accept_stall", stall_req, 1'b1)
`endif
    cyc();
    mc_valid = 1'b0;
    #1;
`ifdef MC_CUT_THROUGH_EN
    `CHK("t2_ct_after_we", rf_we, 1'b0)
`else
    `CHK("t2_drain_we", rf_we, 1'b1)
    `CHK("t2_drain_wa", rf_wa, 5'd8)
    `CHK("t2_drain_wd", rf_wd, 32'hDEAD)
`endif
    `CHK("t2_drain_stall", stall_req, 1'b0)
    cyc();
    #1;
    `CHK("t2_cleared_stall", stall_req, 1'b0)
    `CHK("t2_idle_we", rf_we, 1'b0)

    re1 = 1'b0;
    wb_we = 1'b1; wb_wa = 5'd1;
    wb_wd = 32'h100;
    mc_valid = 1'b1; mc_wa = 5'd3;
    mc_wd = 32'hA;
    #1;
    `CHK("t3_ready0", mc_ready, 1'b1)
    `CHK("t3_wb_wa0", rf_wa, 5'd1)
    cyc();
    wb_wa = 5'd2; wb_wd = 32'h200;
    mc_wa = 5'd4; mc_wd = 32'hB;
    #1;
    `CHK("t3_ready1", mc_ready, 1'b1)
    `CHK("t3_wb_wa1", rf_wa, 5'd2)
    `CHK("t3_wb_wd1", rf_wd, 32'h200)
    cyc();
    wb_wa = 5'd10; wb_wd = 32'h300;
    mc_wa = 5'd7; mc_wd = 32'hC;
    #1;
    `CHK("t3_full_ready", mc_ready, 1'b0)
    `CHK("t3_wb_wa2", rf_wa, 5'd10)
    cyc();
    wb_we = 1'b0; mc_valid = 1'b0;
    #1;
    `CHK("t3_d1_we", rf_we, 1'b1)
    `CHK("t3_d1_wa", rf_wa, 5'd3)
    `CHK("t3_d1_wd", rf_wd, 32'hA)
    `CHK("t3_d1_ready", mc_ready, 1'b0)
    cyc();
    #1;
    `CHK("t3_d2_wa", rf_wa, 5'd4)
    `CHK("t3_d2_wd", rf_wd, 32'hB)
    `CHK("t3_d2_ready", mc_ready, 1'b1)
    cyc();
    #1;
    `CHK("t3_empty_we", rf_we, 1'b0)
    `CHK("t3_empty_wa", rf_wa, 5'd0)
    `CHK("t3_empty_wd", rf_wd, 32'd0)

    mc_valid = 1'b1; mc_wa = 5'd0;
    mc_wd = 32'h55;
    issue_valid = 1'b1; issue_wa = 5'd0;
    #1;
    `CHK("t4_r0_issue_stall", stall_req, 1'b0)
    `CHK("t4_r0_push_we", rf_we, 1'b0)
    cyc();
    mc_valid = 1'b0; issue_valid = 1'b0;
    re1 = 1'b1; ra1 = 5'd0;
    #1;
    `CHK("t4_r0_drain_we", rf_we, 1'b0)
`ifdef MC_CUT_THROUGH_EN
    `CHK("t4_r0_drain_wd", rf_wd, 32'd0)
`else
    `CHK("t4_r0_drain_wd", rf_wd, 32'h55)
`endif
    `CHK("t4_r0_read_stall", stall_req, 1'b0)
    cyc();
    re1 = 1'b0;

    issue_valid = 1'b1; issue_wa = 5'd9;
    #1;
    `CHK("t5_first_issue", stall_req, 1'b0)
    cyc();
    #1;
    `CHK("t5_waw_stall", stall_req, 1'b1)
    cyc();
    issue_valid = 1'b0; re2 = 1'b1;
    ra2 = 5'd9;
    wb_we = 1'b1; wb_wa = 5'd2;
    wb_wd = 32'h5;
    mc_valid = 1'b1; mc_wa = 5'd12;
    mc_wd = 32'h99;
    #1;
    `CHK("t5_still_pending", stall_req, 1'b1)
    cyc();
    mc_valid = 1'b0;
    #1;
    `CHK("t5_hold_wa", rf_wa, 5'd2)
    #1;
    rst_n = 1'b0;
    #1;
    chk_rst("t5_we", 32'(rf_we), 32'd0);
    chk_rst("t5_wa", 32'(rf_wa), 32'd0);
    chk_rst("t5_stall", 32'(stall_req), 32'd0);
    chk_rst("t5_ready", 32'(mc_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    wb_we = 1'b0;
    cyc();
    #1;
    `CHK("t5_post_we", rf_we, 1'b0)
    `CHK("t5_post_stall", stall_req, 1'b0)
    `CHK("t5_post_ready", mc_ready, 1'b1)
    re2 = 1'b0;

`ifdef MC_CUT_THROUGH_EN
    mc_valid = 1'b1; mc_wa = 5'd6;
    mc_wd = 32'h77;
    #1;
    `CHK("t6_ct_we", rf_we, 1'b1)
    `CHK("t6_ct_wa", rf_wa, 5'd6)
    `CHK("t6_ct_wd", rf_wd, 32'h77)
    cyc();
    mc_valid = 1'b0;
    #1;
    `CHK("t6_fifo_empty", rf_we, 1'b0)
`endif

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
